// File: rtl/mem_bus_arbiter_if.sv
// Bundle for mem_bus_arbiter: per-master request side and the shared
// downstream memory bus. The lock input exists only when
// MEM_BUS_ARBITER_LOCK_EN is defined.
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0]        m_req_i;
  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_wvalue_i;
`ifdef MEM_BUS_ARBITER_LOCK_EN
  logic [NUM_MASTERS-1:0]        m_lock_i;
`endif
  logic [NUM_MASTERS-1:0]        m_gnt_o;
  logic [NUM_MASTERS-1:0]        m_rvalid_o;
  logic [DATA_W-1:0]             m_rvalue_o;
  logic                          enable_o;
  logic [STRB_W-1:0]             wstrb_o;
  logic [ADDR_W-1:0]             addr_o;
  logic [DATA_W-1:0]             wvalue_o;
  logic [DATA_W-1:0]             rvalue_i;

  // Arbiter side
  modport slave (
    input  m_req_i, m_wstrb_i, m_addr_i, m_wvalue_i,
`ifdef MEM_BUS_ARBITER_LOCK_EN
    input  m_lock_i,
`endif
    input  rvalue_i,
    output m_gnt_o, m_rvalid_o, m_rvalue_o,
    output enable_o, wstrb_o, addr_o, wvalue_o
  );

  // Requesters plus memory side
  modport master (
    output m_req_i, m_wstrb_i, m_addr_i, m_wvalue_i,
`ifdef MEM_BUS_ARBITER_LOCK_EN
    output m_lock_i,
`endif
    output rvalue_i,
    input  m_gnt_o, m_rvalid_o, m_rvalue_o,
    input  enable_o, wstrb_o, addr_o, wvalue_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory bus between
// NUM_MASTERS requesters. Grant is combinational in the request cycle; the
// registered memory response is routed back to the issuer one cycle later.
// Optional bus locking is enabled by defining MEM_BUS_ARBITER_LOCK_EN.
module mem_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       idx;
  logic                   found;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   resp_valid_q;
  logic [IDX_W-1:0]       resp_id_q;

`ifdef MEM_BUS_ARBITER_LOCK_EN
  logic             lock_q;
  logic [IDX_W-1:0] lock_id_q;

  // While locked only the owner may compete
  always_comb begin
    eligible = bus.m_req_i;
    if (lock_q) eligible = bus.m_req_i & (NUM_MASTERS'(1) << lock_id_q);
  end

  // Lock follows the owner's lock bit on each grant; an idle, unlocked owner releases it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (found) begin
      lock_q    <= bus.m_lock_i[win];
      lock_id_q <= win;
    end else if (lock_q && !bus.m_req_i[lock_id_q] && !bus.m_lock_i[lock_id_q]) begin
      lock_q    <= 1'b0;
    end
  end
`else
  // Every requester competes
  always_comb eligible = bus.m_req_i;
`endif

  // Round-robin scan starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = IDX_W'((32'(last_q) + k) % NUM_MASTERS);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant and bus mux; idle bus drives zeros
  always_comb begin
    bus.m_gnt_o  = '0;
    bus.enable_o = 1'b0;
    bus.wstrb_o  = '0;
    bus.addr_o   = '0;
    bus.wvalue_o = '0;
    if (found) begin
      bus.m_gnt_o[win] = 1'b1;
      bus.enable_o     = 1'b1;
      bus.wstrb_o      = bus.m_wstrb_i[32'(win)*STRB_W +: STRB_W];
      bus.addr_o       = bus.m_addr_i[32'(win)*ADDR_W +: ADDR_W];
      bus.wvalue_o     = bus.m_wvalue_i[32'(win)*DATA_W +: DATA_W];
    end
  end

  // Response routing to the master granted in the previous cycle
  always_comb begin
    bus.m_rvalid_o = '0;
    if (resp_valid_q) bus.m_rvalid_o[resp_id_q] = 1'b1;
    bus.m_rvalue_o = bus.rvalue_i;
  end

  // Round-robin pointer and in-flight response tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= IDX_W'(NUM_MASTERS - 1);
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= found;
      resp_id_q    <= win;
      if (found) last_q <= win;
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single CPU-style memory bus between NUM_MASTERS requesters. Typical requesters are the CPU core, a debug/loader port and a DMA.
- Downstream bus: enable/wstrb/addr/wvalue out, rvalue in. The memory registers rvalue one cycle after enable.
- Grants at most one request per cycle, round-robin, and routes each one-cycle-late response back to the master that issued it.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Strobe width is DATA_W/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_wstrb_i  in  NUM_MASTERS*DATA_W/8  per-master byte strobes; all zero means read.
- m_addr_i  in  NUM_MASTERS*ADDR_W  per-master address.
- m_wvalue_i  in  NUM_MASTERS*DATA_W  per-master write data.
- m_gnt_o  out  NUM_MASTERS  one-hot; request accepted this cycle.
- m_rvalid_o  out  NUM_MASTERS  one-hot; response for that master valid this cycle.
- m_rvalue_o  out  DATA_W  response data, broadcast to all masters; qualify with m_rvalid_o.
- enable_o  out  1  bus access strobe.
- wstrb_o  out  DATA_W/8  bus byte strobes.
- addr_o  out  ADDR_W  bus address.
- wvalue_o  out  DATA_W  bus write data.
- rvalue_i  in  DATA_W  bus read data, valid the cycle after enable_o.

Behaviour:
- Reset (asynchronous, active-high):
  - last_q = NUM_MASTERS-1, resp_valid_q = 0, resp_id_q = 0.
  - All gnt/rvalid outputs 0, enable_o 0, bus outputs 0.
- Grant is combinational in the request cycle:
  - Scan masters starting at last_q+1, wrapping modulo NUM_MASTERS; the first with m_req_i=1 wins.
  - m_gnt_o[win]=1, enable_o=1, and the bus outputs mux the winner's wstrb/addr/wvalue.
- No request: enable_o=0 and wstrb_o/addr_o/wvalue_o driven 0 (never X).
- On a grant: last_q <= win. With no grant, last_q holds.
- Masters hold req and payload stable until the gnt cycle. The arbiter has no buffering, and the payload is sampled only in the gnt cycle.
- Response routing:
  - resp_valid_q <= enable_o; resp_id_q <= win.
  - m_rvalid_o[resp_id_q] = resp_valid_q; m_rvalue_o = rvalue_i.
  - Fixed latency of exactly 1 cycle after gnt.
- Writes also return an rvalid pulse, used as the write ack; the data on a write ack is don't-care.
- Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle. The response of cycle N and the grant of cycle N+1 coexist.
- A master whose request is re-asserted in the cycle of its own rvalid competes normally.
- Single requester: granted every cycle it requests (wrap from last_q to itself).
- All masters requesting continuously: grants rotate 0,1,…,N-1,0,…; no master waits more than NUM_MASTERS-1 cycles.
- Reset mid-access: any pending response is dropped, and no rvalid follows reset release.

Optional Feature:
- Macro: MEM_BUS_ARBITER_LOCK_EN.
- With the macro:
  - Adds input m_lock_i[NUM_MASTERS] plus registers lock_q and lock_id_q.
  - A grant to master i with m_lock_i[i]=1 sets lock_q=1, lock_id_q=i.
  - While lock_q=1, only lock_id_q can be granted; other requests stall.
  - The lock clears on a grant to the owner with m_lock_i=0, or in any cycle where the owner has m_req_i=0 and m_lock_i=0.
  - Reset clears the lock.
  - Round-robin resumes from last_q.
- Without the macro: no lock port, pure round-robin.

Test Plan:
- After reset, m_req_i=2'b11, m0 addr 0x100 read, m1 addr 0x200 write with wstrb 0xF and data 0xDEADBEEF:
  - Cycle 0: gnt=01, addr_o=0x100.
  - Cycle 1: gnt=10, addr_o=0x200, wstrb_o=0xF, and rvalid=01 with m0's read data.
  - Cycle 2: rvalid=10.
- Only m1 requesting for 4 cycles -> gnt=10 each cycle, enable_o=1 throughout, rvalid=10 on cycles 1..4.
- NUM_MASTERS=3, all requesting for 6 cycles -> grant order 0,1,2,0,1,2.
- Idle bus -> enable_o=0, addr_o/wstrb_o/wvalue_o=0, no rvalid the next cycle.
- Assert rst_i in the cycle after a grant -> no rvalid after reset release; the next grant goes to master 0.
- LOCK_EN: m0 granted with lock=1 while m1 requests -> m1 stalls until m0 issues a grant with lock=0; m1 is then granted the following cycle.
